// File: rtl/fp_div_if.sv
// Operand/result bundle for the sequential float divider.
// Latency and timing are set by the divider; the bundle adds no state.
// in_valid/in_ready gate operands; the result side has no backpressure.
interface fp_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] out;
    logic [3:0]  flags;

    modport master (output in_valid, a, b, input in_ready, out_valid, out, flags);
    modport slave  (input in_valid, a, b, output in_ready, out_valid, out, flags);
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single divider (radix-2 restoring), out = a / b, flush-to-zero.
// Latency QBITS+2 edges from accept to the out_valid cycle; one op per QBITS+3 cycles.
// in_ready only when no operation is in progress; out_valid is a pulse with no backpressure.
module fp_div_seq #(
    parameter int QBITS = 26
) (
    input logic     clk,
    input logic     rst_n,
    fp_div_if.slave io
);
    typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} state_t;
    localparam int CW = $clog2(QBITS);

    state_t            state, state_nxt;
    logic [31:0]       a_q, b_q;
    logic [CW-1:0]     cnt;
    logic              sign_q;
    logic signed [9:0] e_q;
    logic [23:0]       mb_q;
    logic [24:0]       rem_q;
    logic [QBITS-1:0]  quo_q;
    logic              spec_q;
    logic [31:0]       spec_res_q;
    logic [3:0]        spec_flg_q;
    logic [31:0]       out_q;
    logic [3:0]        flags_q;

    // DONE also accepts, so the next operand pair overlaps the result cycle.
    assign io.in_ready  = (state == IDLE) || (state == DONE);
    assign io.out_valid = (state == DONE);
    assign io.out       = out_q;
    assign io.flags     = flags_q;

    // Field split and special-case classification of the captured operands.
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
    logic signed [9:0] e_unp;
    logic              u_spec;
    logic [31:0]       u_res;
    logic [3:0]        u_flg;

    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        sgn    = a_q[31] ^ b_q[31];
        e_unp  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        u_spec = 1'b1;
        u_res  = {sgn, 31'd0};
        u_flg  = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            u_res = 32'h7FC0_0000;
            u_flg = 4'b1000;
        end else if (a_inf) begin
            u_res = {sgn, 8'hFF, 23'd0};
        end else if (b_zero) begin
            u_res = {sgn, 8'hFF, 23'd0};
            u_flg = 4'b0100;
        end else if (a_zero || b_inf) begin
            u_res = {sgn, 31'd0};
        end else begin
            u_spec = 1'b0;
        end
    end

    // Divisor is held one bit left so the first step yields the integer bit of mA/mB.
    logic [25:0] rem2, mb2;
    logic [24:0] diff;
    logic        ge;

    always_comb begin
        rem2 = {rem_q, 1'b0};
        mb2  = {1'b0, mb_q, 1'b0};
        ge   = (rem2 >= mb2);
        diff = rem2[24:0] - mb2[24:0];
    end

    logic [QBITS-1:0]  qn;
    logic signed [9:0] e_n, e_f;
    logic [23:0]       mant;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic              guard, sticky, inc;
    logic [31:0]       r_res;
    logic [3:0]        r_flg;

    always_comb begin
        qn     = quo_q[QBITS-1] ? quo_q : {quo_q[QBITS-2:0], 1'b0};
        e_n    = quo_q[QBITS-1] ? e_q : e_q - 10'sd1;
        mant   = qn[QBITS-1 -: 24];
        guard  = qn[QBITS-25];
        sticky = (|qn[QBITS-26:0]) | (|rem_q);
        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, inc};
        e_f    = mant_r[24] ? e_n + 10'sd1 : e_n;
        frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        r_res  = {sign_q, e_f[7:0], frac};
        r_flg  = 4'b0000;
        if (spec_q) begin
            r_res = spec_res_q;
            r_flg = spec_flg_q;
        end else if (e_f >= 10'sd255) begin
            r_res = {sign_q, 8'hFF, 23'd0};
            r_flg = 4'b0010;
        end else if (e_f <= 10'sd0) begin
            r_res = {sign_q, 31'd0};
            r_flg = 4'b0001;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.in_valid) state_nxt = UNPACK;
            UNPACK:  state_nxt = DIV;
            DIV:     if (cnt == CW'(QBITS - 1)) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = io.in_valid ? UNPACK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            e_q        <= 10'sd0;
            mb_q       <= 24'd0;
            rem_q      <= 25'd0;
            quo_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
            spec_flg_q <= 4'd0;
            out_q      <= 32'd0;
            flags_q    <= 4'd0;
        end else begin
            if (io.in_valid && io.in_ready) begin
                a_q <= io.a;
                b_q <= io.b;
            end
            case (state)
                UNPACK: begin
                    sign_q     <= sgn;
                    e_q        <= e_unp;
                    mb_q       <= {1'b1, fb};
                    rem_q      <= {2'b01, fa};
                    quo_q      <= '0;
                    cnt        <= '0;
                    spec_q     <= u_spec;
                    spec_res_q <= u_res;
                    spec_flg_q <= u_flg;
                end
                DIV: begin
                    rem_q <= ge ? diff : rem2[24:0];
                    quo_q <= {quo_q[QBITS-2:0], ge};
                    cnt   <= cnt + 1'b1;
                end
                ROUND: begin
                    out_q   <= r_res;
                    flags_q <= r_flg;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed vectors, busy-hold, back-to-back and reset-abort.
module tb_fp_div_seq;
    localparam int LAT = 28;
    localparam int NV  = 18;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        logic [3:0]  f;
    } vec_t;

    typedef struct packed {
        logic [31:0] o;
        logic [3:0]  f;
        logic [31:0] acc;
        logic [7:0]  id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sbq[$];
    exp_t cur;
    vec_t vecs [NV];

    fp_div_if dif();

    fp_div_seq #(.QBITS(26)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] o, input logic [3:0] f, input int id);
        exp_t e;
        e.o   = o;
        e.f   = f;
        e.acc = cyc;
        e.id  = 8'(id);
        sbq.push_back(e);
    endtask

    // Waits for in_ready, presents one pair, and records the expected result at accept.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] o, input logic [3:0] f, input int id);
        int w = 0;
        @(negedge clk);
        while (!dif.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("ready_before_op[%0d]", id), {31'd0, dif.in_ready}, 32'd1);
        dif.in_valid = 1'b1;
        dif.a = a;
        dif.b = b;
        @(posedge clk);
        #1;
        push_exp(o, f, id);
        dif.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain_pending", sbq.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && dif.out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out_valid out=%h flags=%b expected no pulse", dif.out, dif.flags);
            end else begin
                cur = sbq.pop_front();
                chk($sformatf("out[%0d]", cur.id), dif.out, cur.o);
                chk($sformatf("flags[%0d]", cur.id), {28'd0, dif.flags}, {28'd0, cur.f});
                chk($sformatf("latency[%0d]", cur.id), cyc - cur.acc, LAT);
            end
        end
    end

    initial begin
        int acc1, acc2, busy, pulses;
        logic seen;
        vecs = '{
            '{32'h42C80000, 32'h40800000, 32'h41C80000, 4'b0000},
            '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000},
            '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100},
            '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000},
            '{32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000},
            '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010},
            '{32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001},
            '{32'hC1200000, 32'h40000000, 32'hC0A00000, 4'b0000},
            '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000},
            '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000},
            '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000},
            '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000},
            '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 4'b0000},
            '{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 4'b0000},
            '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000},
            '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001},
            '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000},
            '{32'hBF800000, 32'h80000000, 32'h7F800000, 4'b0100}
        };
        dif.in_valid = 1'b0;
        dif.a = 32'd0;
        dif.b = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, dif.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
        chk("rst_out", dif.out, 32'd0);
        chk("rst_flags", {28'd0, dif.flags}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].f, i);
        drain();

        // Hold in_valid with changing operands while busy; only the first pair counts.
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.a = 32'h42C80000;
        dif.b = 32'h40800000;
        @(posedge clk);
        #1;
        acc1 = cyc;
        push_exp(32'h41C80000, 4'b0000, 100);
        busy = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (dif.out_valid) begin
                seen = 1'b1;
            end else begin
                if (!dif.in_ready) busy++;
                dif.a = $urandom;
                dif.b = $urandom;
            end
        end
        chk("hold_result_seen", {31'd0, seen}, 32'd1);
        chk("hold_busy_cycles", busy, 32'd28);
        chk("hold_ready_at_done", {31'd0, dif.in_ready}, 32'd1);
        dif.a = 32'h3F800000;
        dif.b = 32'h40400000;
        @(posedge clk);
        #1;
        acc2 = cyc;
        push_exp(32'h3EAAAAAB, 4'b0000, 101);
        dif.in_valid = 1'b0;
        chk("back_to_back_spacing", acc2 - acc1, 32'd29);
        drain();

        // Abort an operation at DIV cycle 10 with reset.
        do_op(32'h42C80000, 32'h40800000, 32'h41C80000, 4'b0000, 102);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("abort_in_ready", {31'd0, dif.in_ready}, 32'd1);
        chk("abort_out", dif.out, 32'd0);
        chk("abort_flags", {28'd0, dif.flags}, 32'd0);
        chk("abort_out_valid", {31'd0, dif.out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.out_valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 32'd0);
        do_op(32'hC1200000, 32'h40000000, 32'hC0A00000, 4'b0000, 103);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
